// File: rtl/motor_pwm_pkg.sv
// Shared types and widths for the motor drive path (speed-select FSM and PWM stage).
package motor_pkg;
  localparam int CV_W       = 4;
  localparam int PERIOD_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } pwm_state_t;
endpackage

// File: rtl/motor_pwm_if.sv
// Control/status bundle between the speed-select FSM (master) and the PWM stage (slave).
interface motor_pwm_if;
  import motor_pkg::*;

  logic            i_en;
  logic [CV_W-1:0] i_cv;
  logic            o_pwm;
  logic [CV_W-1:0] o_duty;
  logic            o_busy;
  logic            o_period_start;

  modport master (
    output i_en, i_cv,
    input  o_pwm, o_duty, o_busy, o_period_start
  );

  modport slave (
    input  i_en, i_cv,
    output o_pwm, o_duty, o_busy, o_period_start
  );
endinterface

// File: rtl/motor_pwm_tick_gen.sv
// Prescaler: one-clock tick every PRESCALE clocks while enabled, held at zero otherwise.
module tick_gen #(
  parameter int PRESCALE = 50
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_en,
  output logic o_tick
);
  localparam int              PRE_W    = $clog2(PRESCALE) + 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] r_pre;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pre <= '0;
    end else if (!i_en || r_pre == PRE_LAST) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  assign o_tick = i_en && (r_pre == PRE_LAST);
endmodule

// File: rtl/motor_pwm.sv
// Fixed-frequency PWM drive; duty is latched and slewed one step at a time on period boundaries.
module motor_pwm
  import motor_pkg::*;
#(
  parameter int PRESCALE     = 50,
  parameter int PERIOD       = 15,
  parameter int RAMP_PERIODS = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  motor_pwm_if.slave  bus
);
  localparam logic [CV_W-1:0]   PER_V     = CV_W'(PERIOD);
  localparam logic [CV_W-1:0]   CNT_LAST  = CV_W'(PERIOD - 1);
  localparam int                RAMP_W    = $clog2(RAMP_PERIODS) + 1;
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_PERIODS - 1);
  localparam logic [1:0]        S_IDLE    = IDLE;
  localparam logic [1:0]        S_RAMP    = RAMP;
  localparam logic [1:0]        S_HOLD    = HOLD;

  function automatic logic [CV_W-1:0] sat_cv(input logic [CV_W-1:0] cv);
    return (cv > PER_V) ? PER_V : cv;
  endfunction

  function automatic logic [CV_W-1:0] slew(input logic [CV_W-1:0] cur,
                                           input logic [CV_W-1:0] tgt);
    if (cur < tgt) return cur + CV_W'(1);
    if (cur > tgt) return cur - CV_W'(1);
    return cur;
  endfunction

  logic [1:0]        state;
  logic [CV_W-1:0]   r_cnt;
  logic [RAMP_W-1:0] r_ramp;
  logic [CV_W-1:0]   r_target;
  logic [CV_W-1:0]   r_duty;
  logic              r_pwm;
  logic              r_busy;
  logic              r_start;

  logic              run;
  logic              tick;
  logic              period_end;
  logic              step_end;
  logic [CV_W-1:0]   cnt_nxt;
  logic [CV_W-1:0]   target_nxt;
  logic [CV_W-1:0]   duty_nxt;

  // The prescaler is held in IDLE so the first period after enable is full length.
  assign run = bus.i_en && (state != S_IDLE);

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_en     (run),
    .o_tick   (tick)
  );

  always_comb begin
    period_end = tick && (r_cnt == CNT_LAST);
    step_end   = period_end && (r_ramp == RAMP_LAST);
    cnt_nxt    = r_cnt;
    if (tick) cnt_nxt = (r_cnt == CNT_LAST) ? '0 : r_cnt + CV_W'(1);
    target_nxt = period_end ? sat_cv(bus.i_cv) : r_target;
    duty_nxt   = step_end ? slew(r_duty, target_nxt) : r_duty;
  end

  // Outputs are computed from next-state values so duty, pwm and busy change on the same edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= S_IDLE;
      r_cnt    <= '0;
      r_ramp   <= '0;
      r_target <= '0;
      r_duty   <= '0;
      r_pwm    <= 1'b0;
      r_busy   <= 1'b0;
      r_start  <= 1'b0;
    end else if (!bus.i_en) begin
      state    <= S_IDLE;
      r_cnt    <= '0;
      r_ramp   <= '0;
      r_duty   <= '0;
      r_pwm    <= 1'b0;
      r_busy   <= 1'b0;
      r_start  <= 1'b0;
    end else begin
      r_cnt    <= cnt_nxt;
      r_target <= target_nxt;
      r_duty   <= duty_nxt;
      r_pwm    <= cnt_nxt < duty_nxt;
      r_busy   <= duty_nxt != target_nxt;
      r_start  <= (state == S_IDLE) || period_end;
      if (period_end) r_ramp <= (r_ramp == RAMP_LAST) ? '0 : r_ramp + RAMP_W'(1);
      case (state)
        S_IDLE:  state <= S_RAMP;
        S_RAMP:  if (step_end && duty_nxt == target_nxt) state <= S_HOLD;
        S_HOLD:  if (period_end && target_nxt != r_duty) state <= S_RAMP;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_pwm          = r_pwm;
  assign bus.o_duty         = r_duty;
  assign bus.o_busy         = r_busy;
  assign bus.o_period_start = r_start;
endmodule
